// File: rtl/pcileech_tx_arbiter.sv
// rtl/pcileech_tx_arbiter.sv - shares the 64-bit FT601 word path between TLP and cfg response streams
// cfg words are held in a small FIFO; a multi-word TLP locks the path until its last word (bit 10).
module pcileech_tx_arbiter #(
  parameter int CFG_DEPTH = 4,
  parameter int CNT_W     = 16
) (
  input  logic                       user_clk,
  input  logic                       user_reset_n,
  input  logic [63:0]                tlp_data,
  input  logic                       tlp_valid,
  output logic                       tlp_ready,
  input  logic [63:0]                cfg_data,
  input  logic                       cfg_valid,
  output logic [63:0]                out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(CFG_DEPTH):0] cfg_level,
  output logic [CNT_W-1:0]           cfg_drop_cnt
);

  localparam int AW = $clog2(CFG_DEPTH);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(CFG_DEPTH);
  localparam logic [AW:0] LVL_ONE  = (AW+1)'(1);

  typedef enum logic {ST_IDLE, ST_TLP_LOCK} state_t;
  typedef enum logic {GNT_CFG, GNT_TLP} grant_t;

  state_t           state_q, state_d;
  grant_t           last_grant_q, last_grant_d;
  logic [63:0]      fifo_mem_q [CFG_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [63:0]      out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;

  logic load_en, fifo_empty, fifo_full;
  logic tlp_fire, cfg_pop, cfg_push, cfg_drop;

  // tlp_ready must not depend on tlp_valid, so it is derived from the grant rule alone.
  always_comb begin
    load_en    = !out_valid_q || out_ready;
    fifo_empty = (level_q == '0);
    fifo_full  = (level_q == LVL_FULL);
    tlp_ready  = 1'b0;
    if (user_reset_n && load_en)
      tlp_ready = (state_q == ST_TLP_LOCK) || fifo_empty || (last_grant_q == GNT_CFG);
    tlp_fire = tlp_valid && tlp_ready;
    cfg_pop  = (state_q == ST_IDLE) && load_en && !fifo_empty && !tlp_fire;
    cfg_push = cfg_valid && (!fifo_full || cfg_pop);
    cfg_drop = cfg_valid && fifo_full && !cfg_pop;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    drop_d   = drop_q;
    if (cfg_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (cfg_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({cfg_push, cfg_pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
    if (cfg_drop && (drop_q != '1)) drop_d = drop_q + CNT_W'(1);
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    if (tlp_fire) begin
      out_valid_d = 1'b1;
      out_data_d  = tlp_data;
      if (tlp_data[10]) begin
        state_d      = ST_IDLE;
        last_grant_d = GNT_TLP;
      end else begin
        state_d = ST_TLP_LOCK;
      end
    end else if (cfg_pop) begin
      out_valid_d  = 1'b1;
      out_data_d   = fifo_mem_q[rd_ptr_q];
      last_grant_d = GNT_CFG;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GNT_CFG;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      drop_q       <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      drop_q       <= drop_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
    end
  end

  // Storage only; validity is tracked by the pointers and level.
  always_ff @(posedge user_clk) begin
    if (cfg_push) fifo_mem_q[wr_ptr_q] <= cfg_data;
  end

  assign out_data     = out_data_q;
  assign out_valid    = out_valid_q;
  assign cfg_level    = level_q;
  assign cfg_drop_cnt = drop_q;

endmodule

// File: tb/tb_pcileech_tx_arbiter.sv
// tb/tb_pcileech_tx_arbiter.sv - directed and randomized checks of pcileech_tx_arbiter
// Reference model: a queue for the cfg buffer plus the grant/lock rules applied once per cycle.
module tb_pcileech_tx_arbiter;

  localparam int DEPTH = 4;
  localparam int CW    = 3;
  localparam int CMAX  = (1 << CW) - 1;

  logic        user_clk = 1'b0;
  logic        user_reset_n = 1'b1;
  logic [63:0] tlp_data = '0;
  logic        tlp_valid = 1'b0;
  logic        tlp_ready;
  logic [63:0] cfg_data = '0;
  logic        cfg_valid = 1'b0;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [$clog2(DEPTH):0] cfg_level;
  logic [CW-1:0]          cfg_drop_cnt;

  pcileech_tx_arbiter #(.CFG_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .user_clk(user_clk), .user_reset_n(user_reset_n),
    .tlp_data(tlp_data), .tlp_valid(tlp_valid), .tlp_ready(tlp_ready),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .cfg_level(cfg_level), .cfg_drop_cnt(cfg_drop_cnt)
  );

  always #5 user_clk = ~user_clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [63:0] tlp_q[$];
  logic [63:0] out_log[$];
  int          out_cyc[$];
  logic        tlp_en = 1'b0;

  logic [63:0] m_cq[$];
  logic        m_ov = 1'b0;
  logic [63:0] m_od = '0;
  logic        m_lock = 1'b0;
  logic        m_last_tlp = 1'b0;
  int          m_drop = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_log(input string tag, input logic [63:0] exp[$]);
    chk({tag, "_count"}, 64'(out_log.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < out_log.size(); i++)
      chk(tag, out_log[i], exp[i]);
  endtask

  function automatic logic [63:0] mk_word(input logic last);
    logic [63:0] w;
    w = {$urandom(), $urandom()};
    w[7:0] = 8'h77;
    w[10]  = last;
    return w;
  endfunction

  task automatic push_pkt(input int len);
    for (int i = 0; i < len; i++) tlp_q.push_back(mk_word(i == len - 1));
  endtask

  task automatic drive_tlp();
    tlp_valid = tlp_en && (tlp_q.size() != 0);
    tlp_data  = tlp_valid ? tlp_q[0] : 64'h0;
  endtask

  // One cycle: check DUT against the model, then advance the model by the spec rules.
  task automatic step();
    logic ld, tr, fire, pop, full;
    logic [63:0] popped;
    drive_tlp();
    #1;
    ld = !m_ov || out_ready;
    tr = ld && (m_lock || m_cq.size() == 0 || !m_last_tlp);
    chk("tlp_ready", 64'(tlp_ready), 64'(tr));
    chk("out_valid", 64'(out_valid), 64'(m_ov));
    if (m_ov) chk("out_data", out_data, m_od);
    chk("cfg_level", 64'(cfg_level), 64'(m_cq.size()));
    chk("cfg_drop_cnt", 64'(cfg_drop_cnt), 64'(m_drop));
    if (out_valid && out_ready) begin
      out_log.push_back(out_data);
      out_cyc.push_back(cyc);
    end
    fire   = tlp_valid && tr;
    pop    = !m_lock && ld && (m_cq.size() != 0) && !fire;
    full   = (m_cq.size() == DEPTH);
    popped = 64'h0;
    if (pop) popped = m_cq.pop_front();
    if (cfg_valid) begin
      if (!full || pop) m_cq.push_back(cfg_data);
      else if (m_drop < CMAX) m_drop++;
    end
    if (fire) begin
      m_ov   = 1'b1;
      m_od   = tlp_data;
      m_lock = !tlp_data[10];
      if (tlp_data[10]) m_last_tlp = 1'b1;
      void'(tlp_q.pop_front());
    end else if (pop) begin
      m_ov       = 1'b1;
      m_od       = popped;
      m_last_tlp = 1'b0;
    end else if (out_ready) begin
      m_ov = 1'b0;
    end
    @(posedge user_clk);
    @(negedge user_clk);
    cfg_valid = 1'b0;
    cyc++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic strobe(input logic [63:0] w);
    cfg_valid = 1'b1;
    cfg_data  = w;
    step();
  endtask

  task automatic do_reset();
    user_reset_n = 1'b0;
    tlp_en = 1'b0;
    tlp_q.delete();
    cfg_valid = 1'b0;
    drive_tlp();
    #1;
    m_cq.delete();
    m_ov = 1'b0; m_od = '0; m_lock = 1'b0; m_last_tlp = 1'b0; m_drop = 0;
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_out_data", out_data, 64'h0);
    chk("rst_tlp_ready", 64'(tlp_ready), 64'h0);
    chk("rst_cfg_level", 64'(cfg_level), 64'h0);
    chk("rst_drop_cnt", 64'(cfg_drop_cnt), 64'h0);
    @(posedge user_clk);
    @(negedge user_clk);
    user_reset_n = 1'b1;
  endtask

  initial begin
    logic [63:0] w[4];
    logic [63:0] c[16];
    logic [63:0] exp_q[$];
    int s;

    @(negedge user_clk);
    do_reset();

    // Single cfg word: appears exactly once, two cycles after the strobe.
    out_ready = 1'b1;
    steps(2);
    out_log.delete(); out_cyc.delete();
    c[0] = mk_word(1'b0);
    s = cyc;
    strobe(c[0]);
    steps(4);
    exp_q = '{c[0]};
    chk_log("cfg_single", exp_q);
    if (out_cyc.size() != 0) chk("cfg_latency", 64'(out_cyc[0] - s), 64'd2);

    // 3-word TLP with cfg arriving during word 1: cfg must follow the packet.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) w[i] = mk_word(i == 2);
    for (int i = 0; i < 3; i++) tlp_q.push_back(w[i]);
    tlp_en = 1'b1;
    out_log.delete();
    c[0] = mk_word(1'b0);
    strobe(c[0]);
    steps(6);
    exp_q = '{w[0], w[1], w[2], c[0]};
    chk_log("tlp_lock_order", exp_q);

    // Persistent tie alternates TLP and cfg.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) c[i] = mk_word(1'b0);
    for (int i = 0; i < 3; i++) strobe(c[i]);
    for (int i = 0; i < 5; i++) begin
      w[i % 4] = mk_word(1'b1);
      tlp_q.push_back(w[i % 4]);
    end
    exp_q = '{c[0], tlp_q[0], c[1], tlp_q[1], c[2], tlp_q[2], tlp_q[3], tlp_q[4]};
    out_log.delete();
    tlp_en = 1'b1;
    out_ready = 1'b1;
    steps(10);
    chk_log("tie_alternate", exp_q);

    // Overflow with the output stalled, then drop counter saturation.
    do_reset();
    out_ready = 1'b0;
    w[0] = mk_word(1'b1);
    tlp_q.push_back(w[0]);
    tlp_en = 1'b1;
    steps(2);
    tlp_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      c[i] = mk_word(1'b0);
      strobe(c[i]);
    end
    #1;
    chk("ovf_level", 64'(cfg_level), 64'd4);
    chk("ovf_drop", 64'(cfg_drop_cnt), 64'd2);
    for (int i = 0; i < 10; i++) strobe(mk_word(1'b0));
    #1;
    chk("drop_saturate", 64'(cfg_drop_cnt), 64'(CMAX));
    out_log.delete();
    out_ready = 1'b1;
    steps(8);
    exp_q = '{w[0], c[0], c[1], c[2], c[3]};
    chk_log("ovf_drain", exp_q);

    // Backpressure toggling every cycle across a 4-word packet.
    do_reset();
    for (int i = 0; i < 4; i++) w[i] = mk_word(i == 3);
    for (int i = 0; i < 4; i++) tlp_q.push_back(w[i]);
    tlp_en = 1'b1;
    out_log.delete();
    for (int i = 0; i < 12; i++) begin
      out_ready = (i % 2 == 0);
      step();
    end
    out_ready = 1'b1;
    steps(3);
    exp_q = '{w[0], w[1], w[2], w[3]};
    chk_log("bp_packet", exp_q);

    // Reset while locked with cfg queued, then a fresh tie goes to TLP.
    do_reset();
    out_ready = 1'b1;
    push_pkt(4);
    tlp_en = 1'b1;
    strobe(mk_word(1'b0));
    strobe(mk_word(1'b0));
    #1;
    chk("lock_level", 64'(cfg_level), 64'd2);
    do_reset();
    c[0] = mk_word(1'b0);
    strobe(c[0]);
    w[0] = mk_word(1'b1);
    tlp_q.push_back(w[0]);
    tlp_en = 1'b1;
    out_log.delete();
    steps(4);
    exp_q = '{w[0], c[0]};
    chk_log("post_reset_tie", exp_q);

    // Randomized traffic against the model, with periodic long stalls.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (tlp_q.size() < 4) push_pkt($urandom_range(1, 4));
      tlp_en    = ($urandom_range(0, 3) != 0);
      cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_data  = mk_word(1'($urandom_range(0, 1)));
      out_ready = ((i % 500) < 40) ? 1'b0 : ($urandom_range(0, 3) != 0);
      step();
    end
    tlp_en = 1'b1;
    out_ready = 1'b1;
    steps(40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
